// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Data has priority; a 2-bit starve counter lets a
// waiting fetch through after STARVE_LIMIT consecutive data grants.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort an access that
// waits TIMEOUT_CYC busy cycles without m_ready (ack with zero data, sticky
// bus_err). Without it, an access waits indefinitely and bus_err is 0.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC  = 15,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic [63:0] m_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int unsigned SW = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          m_valid_nxt, m_we_nxt;
  logic [63:0]   m_addr_nxt, m_wdata_nxt;
  logic          i_ack_nxt, d_ack_nxt;
  logic [31:0]   i_rdata_nxt;
  logic [63:0]   d_rdata_nxt;
  logic          fetch_wins, data_wins;
  logic          done, expired;

  // Priority decision on the raw requests; a requester whose ack is showing
  // this cycle still takes part, it just cannot be granted (see IDLE below).
  assign fetch_wins = i_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign data_wins  = d_req && !fetch_wins;
  assign done       = (state != ST_IDLE) && m_ready;

  // Requester stalls: pending request not yet acknowledged
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned TW = 8;

  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          bus_err_nxt;

  assign expired = (state != ST_IDLE) && !m_ready &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // Busy-cycle counter and sticky error flag
  always_comb begin
    tmo_nxt     = '0;
    bus_err_nxt = bus_err | expired;
    if ((state != ST_IDLE) && !done && !expired) tmo_nxt = tmo_cnt + TW'(1);
  end

  // Timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      bus_err <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      bus_err <= bus_err_nxt;
    end
  end
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt   = state;
    starve_nxt  = starve_cnt;
    m_valid_nxt = m_valid;
    m_we_nxt    = m_we;
    m_addr_nxt  = m_addr;
    m_wdata_nxt = m_wdata;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    case (state)
      ST_IDLE: begin
        // The requester being acked this cycle is ignored; if it also wins
        // priority nobody is granted and it drops its request next cycle.
        if (data_wins && !d_ack) begin
          state_nxt   = ST_BUSY_D;
          m_valid_nxt = 1'b1;
          m_we_nxt    = d_we;
          m_addr_nxt  = d_addr;
          m_wdata_nxt = d_wdata;
          if (!i_req)                        starve_nxt = '0;
          else if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + SW'(1);
        end else if (fetch_wins && !i_ack) begin
          state_nxt   = ST_BUSY_I;
          m_valid_nxt = 1'b1;
          m_we_nxt    = 1'b0;
          m_addr_nxt  = i_addr;
          m_wdata_nxt = '0;
          starve_nxt  = '0;
        end
      end
      ST_BUSY_I: begin
        if (done || expired) begin
          state_nxt   = ST_IDLE;
          m_valid_nxt = 1'b0;
          m_we_nxt    = 1'b0;
          i_ack_nxt   = 1'b1;
          i_rdata_nxt = done ? m_rdata[31:0] : '0;
        end
      end
      ST_BUSY_D: begin
        if (done || expired) begin
          state_nxt   = ST_IDLE;
          m_valid_nxt = 1'b0;
          m_we_nxt    = 1'b0;
          d_ack_nxt   = 1'b1;
          d_rdata_nxt = (done && !m_we) ? m_rdata : '0;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        m_valid_nxt = 1'b0;
        m_we_nxt    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset also discards any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      m_valid    <= m_valid_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      i_ack      <= i_ack_nxt;
      d_ack      <= d_ack_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters/memory against a transaction-level
// reference model, followed by directed scenarios for the documented cases.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT_CYC  = 15;
  localparam int unsigned STARVE_LIMIT = 3;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic        i_ack, d_ack, m_valid, m_we, stall_if, stall_mem, bus_err;
  logic [31:0] i_rdata;
  logic [63:0] d_rdata, m_addr, m_wdata;

  mem_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction (who: 0 none, 1 fetch, 2 data)
  int          cur_who = 0, cur_age = 0, starve = 0;
  logic        e_valid = 1'b0, e_we = 1'b0, e_i_ack = 1'b0, e_d_ack = 1'b0, e_err = 1'b0;
  logic [63:0] e_addr = '0, e_wdata = '0, e_d_rdata = '0;
  logic [31:0] e_i_rdata = '0;

  logic i_done = 1'b0, d_done = 1'b0;
  int   exp_seq [8] = '{2, 2, 2, 1, 2, 2, 2, 1};
  int   grant_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled
  task automatic model_step();
    int  win;
    logic was_i, was_d;
    if (reset) begin
      cur_who = 0; cur_age = 0; starve = 0;
      e_valid = 0; e_we = 0; e_i_ack = 0; e_d_ack = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_d_rdata = '0; e_i_rdata = '0;
      return;
    end
    was_i = e_i_ack; was_d = e_d_ack;
    e_i_ack = 0; e_d_ack = 0;
    if (cur_who != 0) begin
      cur_age++;
      if (m_ready || (TMO_EN && cur_age == int'(TIMEOUT_CYC))) begin
        if (!m_ready) e_err = 1'b1;
        if (cur_who == 1) begin
          e_i_ack = 1'b1;
          e_i_rdata = m_ready ? m_rdata[31:0] : 32'h0;
        end else begin
          e_d_ack = 1'b1;
          e_d_rdata = (m_ready && !e_we) ? m_rdata : 64'h0;
        end
        cur_who = 0; e_valid = 1'b0;
      end
    end else begin
      win = 0;
      if (i_req && (!d_req || starve == int'(STARVE_LIMIT))) win = 1;
      else if (d_req) win = 2;
      if ((win == 1 && was_i) || (win == 2 && was_d)) win = 0;
      if (win == 2) begin
        starve = !i_req ? 0 : (starve < int'(STARVE_LIMIT) ? starve + 1 : starve);
        e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
      end else if (win == 1) begin
        starve = 0;
        e_we = 1'b0; e_addr = i_addr;
      end
      if (win != 0) begin
        cur_who = win; cur_age = 0; e_valid = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    check("m_valid", 64'(m_valid), 64'(e_valid));
    check("i_ack", 64'(i_ack), 64'(e_i_ack));
    check("d_ack", 64'(d_ack), 64'(e_d_ack));
    check("bus_err", 64'(bus_err), 64'(e_err));
    check("stall_if", 64'(stall_if), 64'(i_req & ~e_i_ack));
    check("stall_mem", 64'(stall_mem), 64'(d_req & ~e_d_ack));
    if (e_valid) begin
      check("m_addr", m_addr, e_addr);
      check("m_we", 64'(m_we), 64'(e_we));
      if (e_we) check("m_wdata", m_wdata, e_wdata);
    end
    if (e_i_ack) check("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
    if (e_d_ack) check("d_rdata", d_rdata, e_d_rdata);
  endtask

  // One clock: model on the edge, compare 1ns later, return at the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid), 64'h0);
    check({tag, "_m_we"}, 64'(m_we), 64'h0);
    check({tag, "_i_ack"}, 64'(i_ack), 64'h0);
    check({tag, "_d_ack"}, 64'(d_ack), 64'h0);
    check({tag, "_m_addr"}, m_addr, 64'h0);
    check({tag, "_m_wdata"}, m_wdata, 64'h0);
    check({tag, "_i_rdata"}, 64'(i_rdata), 64'h0);
    check({tag, "_d_rdata"}, d_rdata, 64'h0);
    check({tag, "_bus_err"}, 64'(bus_err), 64'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    i_done = 1'b0; d_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Protocol-following random requesters and memory
  task automatic rand_drive(input int unsigned ready_pct);
    reset = ($urandom_range(299, 0) == 0);
    if (e_i_ack) i_done = 1'b1;
    else if (i_done) begin
      i_done = 1'b0;
      if ($urandom_range(1, 0) == 1) i_addr = {$urandom, $urandom};
      else i_req = 1'b0;
    end else if (!i_req) begin
      i_addr = {$urandom, $urandom};
      if ($urandom_range(2, 0) == 0) i_req = 1'b1;
    end
    if (e_d_ack) d_done = 1'b1;
    else if (d_done) begin
      d_done = 1'b0;
      if ($urandom_range(1, 0) == 1) begin
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
        d_we = 1'($urandom_range(1, 0));
      end else d_req = 1'b0;
    end else if (!d_req) begin
      d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      d_we = 1'($urandom_range(1, 0));
      if ($urandom_range(2, 0) == 0) d_req = 1'b1;
    end
    m_ready = ($urandom_range(99, 0) < ready_pct);
    m_rdata = {$urandom, $urandom};
  endtask

  initial begin
    int unsigned pct [6] = '{60, 25, 100, 8, 40, 5};
    int   n;
    logic got_ack, prev_mv;

    @(negedge clk);
    do_reset();
    reset_check("rst");

    foreach (pct[b]) begin
      for (int c = 0; c < 500; c++) begin
        rand_drive(pct[b]);
        tick();
      end
    end

    // Single fetch, memory ready one cycle after m_valid
    do_reset();
    i_req = 1'b1; i_addr = 64'h40; tick();
    check("t1_m_valid", 64'(m_valid), 64'h1);
    check("t1_m_addr", m_addr, 64'h40);
    tick();
    m_ready = 1'b1; m_rdata = 64'h8B020020; tick();
    check("t1_i_ack", 64'(i_ack), 64'h1);
    check("t1_i_rdata", 64'(i_rdata), 64'h8B020020);
    m_ready = 1'b0; tick();
    check("t1_turnaround", 64'(m_valid), 64'h0);
    i_req = 1'b0; tick();

    // Store and fetch arrive together: store first, fetch after turnaround
    do_reset();
    i_req = 1'b1; i_addr = 64'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h55; tick();
    check("t2_m_we", 64'(m_we), 64'h1);
    check("t2_m_addr", m_addr, 64'h100);
    check("t2_m_wdata", m_wdata, 64'h55);
    m_ready = 1'b1; m_rdata = {$urandom, $urandom}; tick();
    check("t2_d_ack", 64'(d_ack), 64'h1);
    check("t2_d_rdata", d_rdata, 64'h0);
    m_ready = 1'b0; tick();
    check("t2_idle", 64'(m_valid), 64'h0);
    d_req = 1'b0; tick();
    check("t2_f_valid", 64'(m_valid), 64'h1);
    check("t2_f_addr", m_addr, 64'h80);
    m_ready = 1'b1; m_rdata = 64'h1234_5678_9ABC_DEF0; tick();
    check("t2_i_rdata", 64'(i_rdata), 64'h9ABC_DEF0);
    m_ready = 1'b0; tick();
    i_req = 1'b0; tick();

    // Both requests held, memory always ready: starve pattern
    do_reset();
    i_req = 1'b1; i_addr = 64'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h2000; m_ready = 1'b1;
    prev_mv = 1'b0;
    grant_q.delete();
    for (int c = 0; c < 40; c++) begin
      m_rdata = {$urandom, $urandom};
      tick();
      if (m_valid && !prev_mv) grant_q.push_back((m_addr == 64'h2000) ? 2 : 1);
      prev_mv = m_valid;
    end
    for (int g = 0; g < 8; g++)
      check($sformatf("t3_grant%0d", g), 64'((g < grant_q.size()) ? grant_q[g] : 0),
            64'(exp_seq[g]));

    // Reset in the second busy cycle of a load, together with m_ready
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; tick();
    tick();
    reset = 1'b1; m_ready = 1'b1; tick();
    reset_check("t4");
    reset = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_no_ack", 64'(d_ack), 64'h0);
    end
    m_ready = 1'b0;

    // Memory never answers
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; m_ready = 1'b0;
    n = 0; got_ack = 1'b0;
    while (!got_ack && n < 40) begin
      tick();
      n++;
      if (d_ack) got_ack = 1'b1;
    end
`ifdef MEM_ARBITER_TIMEOUT_EN
    check("t5_ack_cycle", 64'(n), 64'd16);
    check("t5_d_rdata", d_rdata, 64'h0);
    check("t5_bus_err", 64'(bus_err), 64'h1);
    tick();
    d_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t5_err_sticky", 64'(bus_err), 64'h1);
    end
`else
    check("t5_no_ack", 64'(got_ack), 64'h0);
    check("t5_m_valid", 64'(m_valid), 64'h1);
    check("t5_bus_err", 64'(bus_err), 64'h0);
    d_req = 1'b0;
`endif
    do_reset();
    check("t5_err_cleared", 64'(bus_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: cycles a granted access may wait for m_ready before abort (range 1..255).
REQ-002 Parameter STARVE_LIMIT, default 3: consecutive data grants allowed while fetch is pending (range 1..3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 i_req  input  1  fetch request, held until i_ack.
REQ-006 i_addr  input  64  fetch address.
REQ-007 i_ack  output  1  one-cycle pulse: fetch complete.
REQ-008 i_rdata  output  32  fetched instruction, valid with i_ack.
REQ-009 d_req  input  1  data request, held until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  64  data address.
REQ-012 d_wdata  input  64  store data.
REQ-013 d_ack  output  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  output  64  load data, valid with d_ack; zero for stores.
REQ-015 m_valid  output  1  shared-port access in progress.
REQ-016 m_we  output  1  shared-port write enable.
REQ-017 m_addr  output  64  shared-port address.
REQ-018 m_wdata  output  64  shared-port write data.
REQ-019 m_ready  input  1  memory completion, sampled only while m_valid=1.
REQ-020 m_rdata  input  64  memory read data, valid with m_ready.
REQ-021 stall_if, stall_mem  output  1 each  = i_req&~i_ack and d_req&~d_ack (combinational).
REQ-022 bus_err  output  1  sticky timeout flag.

Function
REQ-023 FSM states IDLE, BUSY_I, BUSY_D; all outputs except stall_* registered.
REQ-024 IDLE with requests sampled at edge t: enter BUSY_x at t; m_valid=1 with m_addr/m_we/m_wdata latched from the winner during cycle t+1 onward, held stable until completion.
REQ-025 Arbitration: d_req wins over i_req, unless starve counter = STARVE_LIMIT and i_req=1, then fetch wins.
REQ-026 Starve counter (2-bit): +1 on each data grant while i_req=1; cleared on fetch grant or when i_req=0 at grant time; saturates at STARVE_LIMIT.
REQ-027 BUSY_x with m_ready=1 at edge k: x_ack=1 and x_rdata captured in cycle k+1 (i_rdata = m_rdata[31:0]); state returns to IDLE; m_valid=0 in cycle k+1.
REQ-028 Minimum request-to-ack latency 2 cycles; one IDLE turnaround cycle between back-to-back accesses.
REQ-029 In the cycle x_ack=1, IDLE ignores x_req (requester drops it next cycle); the other requester may be granted.
REQ-030 m_ready while m_valid=0 ignored; i_ack and d_ack never high together.
REQ-031 Requests changing while BUSY do not alter latched port signals.

Reset
REQ-032 reset at an edge: state IDLE, starve counter 0, timeout counter 0, bus_err 0; in the next cycle m_valid, m_we, i_ack, d_ack 0, m_addr, m_wdata, i_rdata, d_rdata 0.
REQ-033 reset mid-access discards the access: no ack is issued for it; reset dominates m_ready in the same cycle.

Configuration
REQ-034 Macro MEM_ARBITER_TIMEOUT_EN defined: counter counts cycles in BUSY_x; if TIMEOUT_CYC cycles pass with no m_ready, abort: x_ack pulses with x_rdata=0, m_valid drops, bus_err set and held until reset; m_ready on the same edge as expiry takes priority (normal completion).
REQ-035 Macro undefined: no timeout counter, BUSY_x waits indefinitely, bus_err constant 0.

Verification
REQ-036 i_req=1, i_addr=0x40, m_ready high 1 cycle after m_valid, m_rdata=0x8B020020 -> i_ack 3 cycles after i_req, i_rdata=0x8B020020.
REQ-037 d_req=1, d_we=1, d_addr=0x100, d_wdata=0x55 with i_req=1 same cycle -> data granted first, m_we=1, m_addr=0x100, m_wdata=0x55; fetch granted after d_ack plus one IDLE cycle.
REQ-038 d_req and i_req held continuously, m_ready immediate, STARVE_LIMIT=3 -> grant sequence D,D,D,I,D,D,D,I.
REQ-039 Load d_addr=0x200, m_ready after 4 cycles, reset asserted on cycle 2 of BUSY_D -> no d_ack, m_valid=0 next cycle, outputs at reset values.
REQ-040 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYC=15, m_ready never asserted -> d_ack with d_rdata=0 after 15 busy cycles, bus_err=1 until reset; without the macro m_valid stays 1 and bus_err=0.
